// File: rtl/uart_rx_decoder_if.sv
// Link and controller-side signals of the serial Hamming receiver.
// The master side is the transmitter/controller pair, the slave side is the decoder.
interface uart_rx_decoder_if;
  logic       rx_ena;
  logic [4:0] rx_config;
  logic       serial_in;
  logic       rx_ack;
  logic       rx_rts;
  logic [9:0] rx_word;
  logic       rx_valid;
  logic       err_corr;
  logic       err_uncorr;
  logic       err_frame;
  logic [2:0] status;

  modport master (
    output rx_ena, rx_config, serial_in, rx_ack,
    input  rx_rts, rx_word, rx_valid, err_corr, err_uncorr, err_frame, status
  );

  modport slave (
    input  rx_ena, rx_config, serial_in, rx_ack,
    output rx_rts, rx_word, rx_valid, err_corr, err_uncorr, err_frame, status
  );
endinterface

// File: rtl/uart_rx_decoder.sv
// Serial frame receiver: rebuilds a 14-bit Hamming codeword one bit per clk,
// applies single-error correction and holds the 10-bit result until acknowledged.
module uart_rx_decoder #(
  parameter bit SYNC_EN = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  uart_rx_decoder_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DATA   = 3'd1,
    S_STOP   = 3'd2,
    S_DECODE = 3'd3,
    S_HOLD   = 3'd4
  } state_t;

  typedef struct packed {
    state_t      state;
    logic [13:0] code;      // position p of the frame lives in code[14-p]
    logic [3:0]  cnt;
    logic [3:0]  len;
    logic        two_stop;
    logic        stop_idx;
    logic        ferr;
    logic [9:0]  word;
    logic        valid;
    logic        corr;
    logic        uncorr;
    logic        frame;
  } regs_t;

  regs_t r_q, r_d;

  logic        line;
  logic [3:0]  k;
  logic [3:0]  frame_len;
  logic [3:0]  syn;
  logic        flip_en;
  logic [13:0] flip_mask;
  logic [13:0] fixed;
  logic [9:0]  fixed_word;

  generate
    if (SYNC_EN) begin : g_sync
      logic [1:0] sync_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst)              sync_q <= 2'b11;
        else if (!bus.rx_ena) sync_q <= 2'b11;
        else                  sync_q <= {sync_q[0], bus.serial_in};
      end
      assign line = sync_q[1];
    end else begin : g_direct
      assign line = bus.serial_in;
    end
  endgenerate

  // Same 4-bit length rule as the transmitter; k=4 deliberately includes position 8.
  assign k         = bus.rx_config[3:0];
  assign frame_len = k + 4'd2 + {3'b000, |k[3:1]} + {3'b000, |k[3:2]};

  assign syn[0] = ^{r_q.code[13], r_q.code[11], r_q.code[9], r_q.code[7],
                    r_q.code[5],  r_q.code[3],  r_q.code[1]};
  assign syn[1] = ^{r_q.code[12], r_q.code[11], r_q.code[8], r_q.code[7],
                    r_q.code[4],  r_q.code[3],  r_q.code[0]};
  assign syn[2] = ^{r_q.code[10], r_q.code[9],  r_q.code[8], r_q.code[7],
                    r_q.code[2],  r_q.code[1],  r_q.code[0]};
  assign syn[3] = ^r_q.code[6:0];

  // Syndrome 1..14 maps to code[13..0]; 0 and 15 shift the bit out entirely.
  assign flip_mask  = 14'd1 << (4'd14 - syn);
  assign flip_en    = (syn != 4'd0) && (syn <= r_q.len);
  assign fixed      = r_q.code ^ (flip_en ? flip_mask : 14'd0);
  assign fixed_word = {fixed[0], fixed[1], fixed[2], fixed[3], fixed[4],
                       fixed[5], fixed[7], fixed[8], fixed[9], fixed[11]};

  always_comb begin
    // NOTE: every field takes its held value first, so no path through the case leaves a latch.
    r_d = r_q;
    unique case (r_q.state)
      S_IDLE: begin
        if (!line) begin
          r_d.state    = S_DATA;
          r_d.code     = '0;
          r_d.cnt      = '0;
          r_d.len      = frame_len;
          r_d.two_stop = bus.rx_config[4];
          r_d.stop_idx = 1'b0;
          r_d.ferr     = 1'b0;
        end
      end
      S_DATA: begin
        if (r_q.cnt < 4'd14) r_d.code[4'd13 - r_q.cnt] = line;
        r_d.cnt = r_q.cnt + 4'd1;
        if (r_q.cnt + 4'd1 == r_q.len) r_d.state = S_STOP;
      end
      S_STOP: begin
        if (!line) r_d.ferr = 1'b1;
        if (r_q.two_stop && !r_q.stop_idx) r_d.stop_idx = 1'b1;
        else                               r_d.state    = S_DECODE;
      end
      S_DECODE: begin
        r_d.word   = fixed_word;
        r_d.corr   = flip_en;
        r_d.uncorr = syn > r_q.len;
        r_d.frame  = r_q.ferr;
        r_d.valid  = 1'b1;
        r_d.state  = S_HOLD;
      end
      S_HOLD: begin
        // A start bit arriving here is ignored; the line is only watched in IDLE.
        if (bus.rx_ack) begin
          r_d.valid  = 1'b0;
          r_d.corr   = 1'b0;
          r_d.uncorr = 1'b0;
          r_d.frame  = 1'b0;
          r_d.state  = S_IDLE;
        end
      end
      default: r_d.state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers update with <= so every flop sees pre-edge values of the others.
    if (rst)              r_q <= '0;
    else if (!bus.rx_ena) r_q <= '0;
    else                  r_q <= r_d;
  end

  assign bus.rx_rts     = bus.rx_ena & ~r_q.valid & (r_q.state == S_IDLE);
  assign bus.rx_word    = r_q.word;
  assign bus.rx_valid   = r_q.valid;
  assign bus.err_corr   = r_q.corr;
  assign bus.err_uncorr = r_q.uncorr;
  assign bus.err_frame  = r_q.frame;
  assign bus.status     = r_q.state;

endmodule

// File: tb/tb_uart_rx_decoder.sv
// Self-checking bench for uart_rx_decoder: directed frames plus randomized frames
// scored against a position-based Hamming reference model.
module tb_uart_rx_decoder;

  logic clk = 1'b0;
  logic rst;

  uart_rx_decoder_if bus ();

  uart_rx_decoder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [9:0] word;
    bit         corr;
    bit         uncorr;
    bit         frame;
  } result_t;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int frame_len(input int k);
    return k + 2 + ((k >= 2) ? 1 : 0) + ((k >= 4) ? 1 : 0);
  endfunction

  function automatic logic [14:1] to_pos(input logic [13:0] c);
    logic [14:1] r;
    for (int p = 1; p <= 14; p++) r[p] = c[14-p];
    return r;
  endfunction

  // Data fills the non-power-of-two positions in order; parity p covers positions sharing bit p.
  function automatic logic [14:1] encode(input logic [9:0] w);
    logic [14:1] b;
    int j;
    b = '0;
    j = 0;
    for (int p = 1; p <= 14; p++)
      if ((p & (p - 1)) != 0) begin
        b[p] = w[j];
        j++;
      end
    for (int pp = 1; pp <= 8; pp = pp * 2) begin
      logic x;
      x = 1'b0;
      for (int p = 1; p <= 14; p++)
        if ((p & pp) != 0 && p != pp) x = x ^ b[p];
      b[pp] = x;
    end
    return b;
  endfunction

  // Syndrome as the XOR of the indices of all set positions (unsent positions read as 0).
  function automatic result_t model(input logic [14:1] rx, input int n, input bit frame_bad);
    result_t r;
    int syn;
    int j;
    syn = 0;
    for (int p = 1; p <= 14; p++)
      if (p > n) rx[p] = 1'b0;
      else if (rx[p]) syn = syn ^ p;
    r.corr   = 1'b0;
    r.uncorr = 1'b0;
    r.frame  = frame_bad;
    if (syn != 0 && syn <= n) begin
      rx[syn] = ~rx[syn];
      r.corr  = 1'b1;
    end else if (syn > n) begin
      r.uncorr = 1'b1;
    end
    r.word = '0;
    j = 0;
    for (int p = 1; p <= 14; p++)
      if ((p & (p - 1)) != 0) begin
        r.word[j] = rx[p];
        j++;
      end
    return r;
  endfunction

  task automatic send_frame(input logic [14:1] tx, input int n, input bit two_stop,
                            input logic [1:0] stops, input bit scramble);
    @(negedge clk) bus.serial_in = 1'b0;
    for (int p = 1; p <= n; p++) begin
      @(negedge clk) bus.serial_in = tx[p];
      if (scramble && p == 1) bus.rx_config = 5'($urandom);
    end
    @(negedge clk) bus.serial_in = stops[0];
    if (two_stop) begin
      @(negedge clk) bus.serial_in = stops[1];
    end
    @(negedge clk) bus.serial_in = 1'b1;
  endtask

  // Called on the negedge just after the last stop bit was sampled.
  task automatic expect_result(input string tag, input result_t e);
    check({tag, "_early_valid"}, bus.rx_valid, 1'b0);
    @(negedge clk);
    check({tag, "_valid"},  bus.rx_valid,   1'b1);
    check({tag, "_word"},   bus.rx_word,    e.word);
    check({tag, "_corr"},   bus.err_corr,   e.corr);
    check({tag, "_uncorr"}, bus.err_uncorr, e.uncorr);
    check({tag, "_frame"},  bus.err_frame,  e.frame);
    check({tag, "_status"}, bus.status,     3'd4);
    check({tag, "_rts"},    bus.rx_rts,     1'b0);
  endtask

  task automatic do_ack(input string tag);
    repeat ($urandom_range(0, 2)) @(negedge clk);
    bus.rx_ack = 1'b1;
    @(negedge clk);
    bus.rx_ack = 1'b0;
    check({tag, "_ack_valid"},  bus.rx_valid,   1'b0);
    check({tag, "_ack_corr"},   bus.err_corr,   1'b0);
    check({tag, "_ack_uncorr"}, bus.err_uncorr, 1'b0);
    check({tag, "_ack_frame"},  bus.err_frame,  1'b0);
    check({tag, "_ack_rts"},    bus.rx_rts,     1'b1);
    check({tag, "_ack_status"}, bus.status,     3'd0);
  endtask

  function automatic result_t mk(input logic [9:0] w, input bit c, input bit u, input bit f);
    result_t r;
    r.word   = w;
    r.corr   = c;
    r.uncorr = u;
    r.frame  = f;
    return r;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [14:1] tx;
    logic [9:0]  held_word;
    result_t     e;
    int          k, n, nflip;
    bit          two, fbad;
    logic [1:0]  stops;
    logic [9:0]  w;

    rst           = 1'b1;
    bus.rx_ena    = 1'b1;
    bus.rx_config = 5'd10;
    bus.serial_in = 1'b1;
    bus.rx_ack    = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("rst_status", bus.status,     3'd0);
    check("rst_valid",  bus.rx_valid,   1'b0);
    check("rst_word",   bus.rx_word,    10'd0);
    check("rst_corr",   bus.err_corr,   1'b0);
    check("rst_uncorr", bus.err_uncorr, 1'b0);
    check("rst_frame",  bus.err_frame,  1'b0);
    check("rst_rts",    bus.rx_rts,     1'b1);

    bus.rx_ena = 1'b0;
    @(negedge clk);
    check("ena_low_rts", bus.rx_rts, 1'b0);
    bus.rx_ena = 1'b1;
    @(negedge clk);
    check("ena_high_rts", bus.rx_rts, 1'b1);

    // Dropping rx_ena mid-frame abandons the frame.
    bus.serial_in = 1'b0;
    repeat (4) @(negedge clk) bus.serial_in = 1'b1;
    check("ena_mid_status_busy", bus.status, 3'd1);
    bus.rx_ena = 1'b0;
    @(negedge clk);
    check("ena_mid_status", bus.status, 3'd0);
    bus.rx_ena = 1'b1;
    @(negedge clk);

    // Clean k=10 word 001.
    bus.rx_config = 5'd10;
    send_frame(to_pos(14'h3800), 14, 1'b0, 2'b11, 1'b0);
    expect_result("t1", mk(10'h001, 1'b0, 1'b0, 1'b0));
    do_ack("t1");

    // code[9] flipped -> syndrome 5, corrected.
    send_frame(to_pos(14'h3A00), 14, 1'b0, 2'b11, 1'b0);
    expect_result("t2", mk(10'h001, 1'b1, 1'b0, 1'b0));
    do_ack("t2");

    // Positions 1 and 14 flipped -> syndrome 15, passed through uncorrected.
    send_frame(to_pos(14'h1801), 14, 1'b0, 2'b11, 1'b0);
    expect_result("t3", mk(10'h201, 1'b0, 1'b1, 1'b0));
    do_ack("t3");

    // k=1, two stop bits.
    bus.rx_config = {1'b1, 4'd1};
    send_frame(to_pos(14'h3800), 3, 1'b1, 2'b11, 1'b0);
    expect_result("t4a", mk(10'h001, 1'b0, 1'b0, 1'b0));
    do_ack("t4a");
    bus.rx_config = {1'b1, 4'd1};
    send_frame(to_pos(14'h3800), 3, 1'b1, 2'b01, 1'b0);
    expect_result("t4b", mk(10'h001, 1'b0, 1'b0, 1'b1));
    do_ack("t4b");

    // Frame sent into HOLD is ignored; word survives until acknowledged.
    bus.rx_config = 5'd10;
    send_frame(encode(10'h2A5), 14, 1'b0, 2'b11, 1'b0);
    expect_result("t5", mk(10'h2A5, 1'b0, 1'b0, 1'b0));
    held_word = bus.rx_word;
    send_frame(encode(10'h15A), 14, 1'b0, 2'b11, 1'b0);
    repeat (2) @(negedge clk);
    check("t5_hold_rts",    bus.rx_rts,   1'b0);
    check("t5_hold_valid",  bus.rx_valid, 1'b1);
    check("t5_hold_word",   bus.rx_word,  10'h2A5);
    check("t5_hold_status", bus.status,   3'd4);
    do_ack("t5");
    check("t5_word_kept",   bus.rx_word,  held_word);

    // Async reset in the middle of DATA.
    bus.rx_config = 5'd10;
    @(negedge clk) bus.serial_in = 1'b0;
    repeat (5) @(negedge clk) bus.serial_in = 1'($urandom);
    @(negedge clk);
    rst           = 1'b1;
    bus.serial_in = 1'b1;
    #1;
    check("t6_rst_status", bus.status,   3'd0);
    check("t6_rst_valid",  bus.rx_valid, 1'b0);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    send_frame(encode(10'h3C3), 14, 1'b0, 2'b11, 1'b0);
    expect_result("t6", mk(10'h3C3, 1'b0, 1'b0, 1'b0));
    do_ack("t6");

    // Randomized frames: k, word, stop count, bit errors and stop errors.
    for (int f = 0; f < 60; f++) begin
      k     = $urandom_range(1, 10);
      n     = frame_len(k);
      w     = 10'($urandom) & ((10'd1 << k) - 10'd1);
      two   = 1'($urandom);
      tx    = encode(w);
      nflip = $urandom_range(0, 3);
      if (nflip == 1 || nflip == 2) tx[$urandom_range(1, n)] ^= 1'b1;
      if (nflip == 2)               tx[$urandom_range(1, n)] ^= 1'b1;
      stops[0] = ($urandom_range(0, 7) != 0);
      stops[1] = ($urandom_range(0, 7) != 0);
      fbad     = !stops[0] || (two && !stops[1]);
      e        = model(tx, n, fbad);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      bus.rx_config = {two, 4'(k)};
      send_frame(tx, n, two, stops, 1'b1);
      expect_result($sformatf("rnd%0d", f), e);
      do_ack($sformatf("rnd%0d", f));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
